instr_fetch: RTL and testbench

- Instruction fetch stage. Generates sequential and redirected PCs, issues one-outstanding requests to instruction memory, and presents {pc, instr} to decode through a holding register plus a 1-entry skid slot.
- Consumes decode's stall and redirect outputs (jump_branch, jump_target, jump_reg, jr_pc) and honours MIPS branch-delay-slot semantics.

---
 rtl/instr_fetch.sv | 163 ++++++++++++++++
 tb/tb_instr_fetch.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one-outstanding imem requests, ID holding register plus a 1-entry skid,
// and MIPS delay-slot redirect handling through a pending-target register.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    output logic [31:0] pc_id,
    output logic [31:0] instr_id,
    output logic        instr_valid_id,
    input  logic        stall,
    input  logic        jump_branch,
    input  logic        jump_target,
    input  logic        jump_reg,
    input  logic [31:0] jr_pc
);

    typedef enum logic [1:0] {StStart, StWait, StSkid} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_pc_q, pend_pc_d;

    logic        consume, redirect, id_free, enter, to_skid;
    logic [31:0] pc_id_p4, target, enter_pc, enter_instr, next_addr;

    assign consume  = id_valid_q & ~stall;
    assign redirect = consume & (jump_reg | jump_target | jump_branch);
    assign id_free  = ~id_valid_q | consume;
    assign pc_id_p4 = id_pc_q + 32'd4;

    always_comb begin
        if (jump_reg) begin
            target = jr_pc;
        end else if (jump_target) begin
            target = {pc_id_p4[31:28], id_instr_q[25:0], 2'b00};
        end else begin
            target = pc_id_p4 + {{14{id_instr_q[15]}}, id_instr_q[15:0], 2'b00};
        end
    end

    always_comb begin
        state_d     = state_q;
        enter       = 1'b0;
        to_skid     = 1'b0;
        imem_req    = 1'b0;
        enter_pc    = addr_q;
        enter_instr = imem_rdata;
        unique case (state_q)
            StStart: begin
                imem_req = 1'b1;
                state_d  = StWait;
            end
            StWait: begin
                if (imem_rvalid) begin
                    if (id_free) begin
                        enter    = 1'b1;
                        imem_req = 1'b1;
                    end else begin
                        to_skid = 1'b1;
                        state_d = StSkid;
                    end
                end
            end
            StSkid: begin
                enter_pc    = skid_pc_q;
                enter_instr = skid_instr_q;
                if (id_free) begin
                    enter    = 1'b1;
                    imem_req = 1'b1;
                    state_d  = StWait;
                end
            end
            default: state_d = StStart;
        endcase
        if (rst) begin
            imem_req = 1'b0;
        end
    end

    // The entering instruction is always the delay slot of a redirect seen now or earlier.
    always_comb begin
        if (state_q == StStart) begin
            next_addr = RESET_PC;
        end else if (redirect) begin
            next_addr = target;
        end else if (pend_valid_q) begin
            next_addr = pend_pc_q;
        end else begin
            next_addr = enter_pc + 32'd4;
        end
    end

    assign imem_addr = imem_req ? next_addr : addr_q;

    always_comb begin
        addr_d       = imem_req ? next_addr : addr_q;
        id_valid_d   = id_valid_q;
        id_pc_d      = id_pc_q;
        id_instr_d   = id_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        if (enter) begin
            id_valid_d = 1'b1;
            id_pc_d    = enter_pc;
            id_instr_d = enter_instr;
        end else if (consume) begin
            id_valid_d = 1'b0;
            id_instr_d = 32'h0;
        end
        if (to_skid) begin
            skid_pc_d    = addr_q;
            skid_instr_d = imem_rdata;
        end
        if (enter) begin
            pend_valid_d = 1'b0;
        end else if (redirect) begin
            pend_valid_d = 1'b1;
            pend_pc_d    = target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StStart;
            addr_q       <= RESET_PC;
            id_valid_q   <= 1'b0;
            id_pc_q      <= RESET_PC;
            id_instr_q   <= 32'h0;
            skid_pc_q    <= 32'h0;
            skid_instr_q <= 32'h0;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            id_valid_q   <= id_valid_d;
            id_pc_q      <= id_pc_d;
            id_instr_q   <= id_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

    assign pc_id          = id_pc_q;
    assign instr_id       = id_instr_q;
    assign instr_valid_id = id_valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a latency-programmable one-outstanding instruction memory.
module tb_instr_fetch;

    logic        clk, rst, imem_req, imem_rvalid, instr_valid_id, stall;
    logic        jump_branch, jump_target, jump_reg;
    logic [31:0] imem_addr, imem_rdata, pc_id, instr_id, jr_pc;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_rvalid    (imem_rvalid),
        .pc_id          (pc_id),
        .instr_id       (instr_id),
        .instr_valid_id (instr_valid_id),
        .stall          (stall),
        .jump_branch    (jump_branch),
        .jump_target    (jump_target),
        .jump_reg       (jump_reg),
        .jr_pc          (jr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp, n_bad, cyc, mem_lat, resp_cyc;
    int          overlap, req_in_rst, addr_unstable;
    logic        busy, last_req;
    logic [31:0] busy_addr, last_addr;
    logic [31:0] cons_log[$];
    logic [31:0] req_log[$];
    logic [31:0] rd_pc[2];
    int          rd_kind[2];  // 0 none, 1 branch, 2 j, 3 jr

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0010: return 32'h1000_0003;  // beq, imm 3
            32'h0000_0040: return 32'h03E0_0008;  // jr
            32'h2000_0000: return 32'h0800_0010;  // j, target field 0x10
            default:       return {8'hA5, a[23:0]};
        endcase
    endfunction

    function automatic logic [31:0] cons_at(input int i);
        if (i < 0 || i >= cons_log.size()) return 32'hDEAD_BEEF;
        return cons_log[i];
    endfunction

    function automatic logic [31:0] req_at(input int i);
        if (i < 0 || i >= req_log.size()) return 32'hDEAD_BEEF;
        return req_log[i];
    endfunction

    function automatic int find_cons(input logic [31:0] v);
        for (int i = 0; i < cons_log.size(); i++) if (cons_log[i] == v) return i;
        return -1;
    endfunction

    function automatic int find_req(input logic [31:0] v);
        for (int i = 0; i < req_log.size(); i++) if (req_log[i] == v) return i;
        return -1;
    endfunction

    // Called at the falling edge; returns at the next falling edge.
    task automatic tick();
        #4;
        last_req  = imem_req;
        last_addr = imem_addr;
        if (imem_req === 1'b1) begin
            if (rst) req_in_rst++;
            if (busy) overlap++;
            busy      = 1'b1;
            busy_addr = imem_addr;
            resp_cyc  = cyc + mem_lat;
            if (!rst) req_log.push_back(imem_addr);
        end else if (busy && imem_addr !== busy_addr) begin
            addr_unstable++;
        end
        if (!rst && instr_valid_id === 1'b1 && !stall) cons_log.push_back(pc_id);
        if (rst) busy = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (busy && cyc == resp_cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(busy_addr);
            busy        = 1'b0;
        end
        #4;
        jump_branch = 1'b0;
        jump_target = 1'b0;
        jump_reg    = 1'b0;
        if (!rst && instr_valid_id === 1'b1) begin
            for (int k = 0; k < 2; k++) begin
                if (rd_kind[k] != 0 && pc_id == rd_pc[k]) begin
                    jump_branch = (rd_kind[k] == 1);
                    jump_target = (rd_kind[k] == 2);
                    jump_reg    = (rd_kind[k] == 3);
                end
            end
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        stall      = 1'b0;
        rd_kind[0] = 0;
        rd_kind[1] = 0;
        tick();
        tick();
        rst = 1'b0;
        cons_log.delete();
        req_log.delete();
    endtask

    task automatic test_reset();
        mem_lat = 1;
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (instr_valid_id !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", instr_valid_id); end
        n_cmp++; if (instr_id !== 32'h0) begin n_bad++; $display("FAIL rst_instr: got %h want 0", instr_id); end
        n_cmp++; if (pc_id !== 32'h0) begin n_bad++; $display("FAIL rst_pc: got %h want 0", pc_id); end
        n_cmp++; if (last_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", last_req); end
        rst = 1'b0;
        cons_log.delete();
        req_log.delete();
        tick();
        n_cmp++; if (last_req !== 1'b1 || last_addr !== 32'h0) begin
            n_bad++; $display("FAIL first_req: got %b/%h want 1/00000000", last_req, last_addr); end
        n_cmp++; if (instr_valid_id !== 1'b0) begin n_bad++; $display("FAIL early_valid: got %b want 0", instr_valid_id); end
        tick();
        n_cmp++; if (instr_valid_id !== 1'b1 || pc_id !== 32'h0 || instr_id !== mem_word(32'h0)) begin
            n_bad++; $display("FAIL first_valid: got %b/%h/%h want 1/00000000/%h", instr_valid_id, pc_id, instr_id, mem_word(32'h0)); end
    endtask

    task automatic test_sequential();
        mem_lat = 1;
        do_reset();
        repeat (6) tick();
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (cons_at(i) !== 32'(4 * i)) begin
                n_bad++; $display("FAIL seq_pc[%0d]: got %h want %h", i, cons_at(i), 32'(4 * i)); end
        end
        n_cmp++; if (req_log.size() != 6) begin n_bad++; $display("FAIL seq_reqs: got %0d want 6", req_log.size()); end
    endtask

    task automatic test_stall();
        int n0;
        logic [31:0] exp_c[6];
        exp_c = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
        mem_lat = 1;
        do_reset();
        for (int i = 0; i < 20 && !(instr_valid_id === 1'b1 && pc_id == 32'h8); i++) tick();
        n_cmp++; if (!(instr_valid_id === 1'b1 && pc_id === 32'h8)) begin
            n_bad++; $display("FAIL stall_reach: got %b/%h want 1/00000008", instr_valid_id, pc_id); end
        n0 = req_log.size();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (pc_id !== 32'h8 || instr_id !== mem_word(32'h8) || instr_valid_id !== 1'b1) begin
                n_bad++; $display("FAIL stall_hold[%0d]: got %h/%h want 00000008/%h", i, pc_id, instr_id, mem_word(32'h8)); end
            tick();
        end
        n_cmp++; if (req_log.size() != n0) begin n_bad++; $display("FAIL stall_req: got %0d want %0d", req_log.size(), n0); end
        stall = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (cons_at(i) !== exp_c[i]) begin
                n_bad++; $display("FAIL stall_pc[%0d]: got %h want %h", i, cons_at(i), exp_c[i]); end
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (req_at(i) !== 32'(4 * i)) begin
                n_bad++; $display("FAIL stall_addr[%0d]: got %h want %h", i, req_at(i), 32'(4 * i)); end
        end
    endtask

    task automatic test_branch();
        logic [31:0] exp_c[8];
        exp_c = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h20, 32'h24};
        mem_lat = 1;
        do_reset();
        rd_pc[0] = 32'h10; rd_kind[0] = 1;
        repeat (10) tick();
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (cons_at(i) !== exp_c[i]) begin
                n_bad++; $display("FAIL br_pc[%0d]: got %h want %h", i, cons_at(i), exp_c[i]); end
        end
        n_cmp++; if (find_req(32'h18) != -1) begin n_bad++; $display("FAIL br_no18: got index %0d want -1", find_req(32'h18)); end
    endtask

    task automatic test_jr_pending();
        int ix, rx;
        mem_lat = 4;
        do_reset();
        rd_pc[0] = 32'h40; rd_kind[0] = 3; jr_pc = 32'h100;
        for (int i = 0; i < 300 && find_cons(32'h104) < 0; i++) tick();
        ix = find_cons(32'h40);
        n_cmp++; if (cons_at(ix + 1) !== 32'h44) begin n_bad++; $display("FAIL jr_slot: got %h want 00000044", cons_at(ix + 1)); end
        n_cmp++; if (cons_at(ix + 2) !== 32'h100) begin n_bad++; $display("FAIL jr_tgt: got %h want 00000100", cons_at(ix + 2)); end
        n_cmp++; if (cons_at(ix + 3) !== 32'h104) begin n_bad++; $display("FAIL jr_next: got %h want 00000104", cons_at(ix + 3)); end
        rx = find_req(32'h44);
        n_cmp++; if (req_at(rx + 1) !== 32'h100) begin n_bad++; $display("FAIL jr_addr: got %h want 00000100", req_at(rx + 1)); end
        n_cmp++; if (req_at(rx + 2) !== 32'h104) begin n_bad++; $display("FAIL jr_pend_clr: got %h want 00000104", req_at(rx + 2)); end
        n_cmp++; if (find_req(32'h48) != -1) begin n_bad++; $display("FAIL jr_no48: got index %0d want -1", find_req(32'h48)); end
    endtask

    task automatic test_jump();
        logic [31:0] exp_c[6];
        exp_c = '{32'h0, 32'h4, 32'h2000_0000, 32'h2000_0004, 32'h2000_0040, 32'h2000_0044};
        mem_lat = 1;
        do_reset();
        rd_pc[0] = 32'h0;         rd_kind[0] = 3; jr_pc = 32'h2000_0000;
        rd_pc[1] = 32'h2000_0000; rd_kind[1] = 2;
        repeat (8) tick();
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (cons_at(i) !== exp_c[i]) begin
                n_bad++; $display("FAIL j_pc[%0d]: got %h want %h", i, cons_at(i), exp_c[i]); end
        end
    endtask

    task automatic test_reset_mid();
        // Skid full, then reset.
        mem_lat = 1;
        do_reset();
        for (int i = 0; i < 20 && !(instr_valid_id === 1'b1 && pc_id == 32'h8); i++) tick();
        stall = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        n_cmp++; if (instr_valid_id !== 1'b0 || instr_id !== 32'h0 || pc_id !== 32'h0) begin
            n_bad++; $display("FAIL mid_rst_a: got %b/%h/%h want 0/0/0", instr_valid_id, instr_id, pc_id); end
        rst = 1'b0; stall = 1'b0;
        cons_log.delete(); req_log.delete();
        tick();
        n_cmp++; if (last_req !== 1'b1 || last_addr !== 32'h0) begin
            n_bad++; $display("FAIL mid_req_a: got %b/%h want 1/00000000", last_req, last_addr); end
        repeat (3) tick();
        n_cmp++; if (cons_at(0) !== 32'h0 || cons_at(1) !== 32'h4 || cons_log.size() != 2) begin
            n_bad++; $display("FAIL mid_seq_a: got %h,%h n=%0d want 0,4 n=2", cons_at(0), cons_at(1), cons_log.size()); end
        // Late response in the reset cycle.
        mem_lat = 3;
        do_reset();
        for (int i = 0; i < 20 && instr_valid_id !== 1'b1; i++) tick();
        stall = 1'b1;
        for (int i = 0; i < 10 && imem_rvalid !== 1'b1; i++) tick();
        n_cmp++; if (imem_rvalid !== 1'b1) begin n_bad++; $display("FAIL mid_late: got rvalid %b want 1", imem_rvalid); end
        rst = 1'b1;
        tick();
        n_cmp++; if (instr_valid_id !== 1'b0 || instr_id !== 32'h0) begin
            n_bad++; $display("FAIL mid_rst_b: got %b/%h want 0/0", instr_valid_id, instr_id); end
        rst = 1'b0; stall = 1'b0;
        cons_log.delete(); req_log.delete();
        tick();
        n_cmp++; if (last_req !== 1'b1 || last_addr !== 32'h0) begin
            n_bad++; $display("FAIL mid_req_b: got %b/%h want 1/00000000", last_req, last_addr); end
        repeat (5) tick();
        n_cmp++; if (req_log.size() != 2 || req_at(1) !== 32'h4) begin
            n_bad++; $display("FAIL mid_reqs_b: got n=%0d [1]=%h want n=2 [1]=00000004", req_log.size(), req_at(1)); end
        n_cmp++; if (cons_log.size() != 1 || cons_at(0) !== 32'h0) begin
            n_bad++; $display("FAIL mid_seq_b: got n=%0d [0]=%h want n=1 [0]=0", cons_log.size(), cons_at(0)); end
    endtask

    task automatic test_protocol();
        n_cmp++; if (overlap != 0) begin n_bad++; $display("FAIL proto_overlap: got %0d want 0", overlap); end
        n_cmp++; if (req_in_rst != 0) begin n_bad++; $display("FAIL proto_req_rst: got %0d want 0", req_in_rst); end
        n_cmp++; if (addr_unstable != 0) begin n_bad++; $display("FAIL proto_addr_hold: got %0d want 0", addr_unstable); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; mem_lat = 1; resp_cyc = 0;
        overlap = 0; req_in_rst = 0; addr_unstable = 0;
        busy = 1'b0; busy_addr = 32'h0; last_req = 1'b0; last_addr = 32'h0;
        rst = 1'b1; stall = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        jump_branch = 1'b0; jump_target = 1'b0; jump_reg = 1'b0; jr_pc = 32'h0;
        rd_pc[0] = 32'h0; rd_pc[1] = 32'h0; rd_kind[0] = 0; rd_kind[1] = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_jr_pending();
        test_jump();
        test_reset_mid();
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
